// File: rtl/irq_event_pkg.sv
// Shared register map, STATUS bit positions and helpers for irq_event_ctrl.
package irq_event_pkg;

  localparam int unsigned IRQ_ID_WIDTH   = 5;
  localparam int unsigned STATUS_IRQ_BIT = 31;
  localparam int unsigned STATUS_EVT_BIT = 30;

  // Word index taken from PADDR[4:2]
  typedef enum logic [2:0] {
    RegIrqEnable  = 3'd0,
    RegIrqPending = 3'd1,
    RegIrqSet     = 3'd2,
    RegIrqClear   = 3'd3,
    RegEvtEnable  = 3'd4,
    RegEvtPending = 3'd5,
    RegEvtClear   = 3'd6,
    RegStatus     = 3'd7
  } reg_idx_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IRQ_ID_WIDTH-1:0] lowest_set_idx(input logic [31:0] vec);
    logic [IRQ_ID_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = IRQ_ID_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/line_edge_detect.sv
// Per-line rising-edge detector. With IRQ_EVENT_SYNC_EN defined, each line first
// passes through a 2-flop synchronizer so lines may be asynchronous to HCLK.
module line_edge_detect #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH-1:0] lines_i,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sampled;
  logic [WIDTH-1:0] prev_q;

`ifdef IRQ_EVENT_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= lines_i;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = lines_i;
`endif

  // prev resets to 0 so a line already high at reset release yields one edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prev_q <= '0;
    end else begin
      prev_q <= sampled;
    end
  end

  assign edge_o = sampled & ~prev_q;

endmodule

// File: rtl/irq_event_ctrl.sv
// APB interrupt/event collector: edge-detects lines into pending bits, masks them and
// drives irq_o/irq_id_o/event_o. Define IRQ_EVENT_SYNC_EN to synchronize input lines.
module irq_event_ctrl
  import irq_event_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_LINES      = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_LINES-1:0]      irq_lines_i,
  input  logic [NUM_LINES-1:0]      event_lines_i,
  input  logic                      irq_ack_i,
  input  logic [IRQ_ID_WIDTH-1:0]   irq_ack_id_i,
  output logic                      irq_o,
  output logic [IRQ_ID_WIDTH-1:0]   irq_id_o,
  output logic                      event_o
);

  logic                 apb_write;
  logic                 apb_read;
  reg_idx_e             reg_idx;
  logic [NUM_LINES-1:0] wdata_lines;
  logic [31:0]          rdata;

  logic [NUM_LINES-1:0] irq_en_q, irq_en_d;
  logic [NUM_LINES-1:0] irq_pend_q, irq_pend_d;
  logic [NUM_LINES-1:0] evt_en_q, evt_en_d;
  logic [NUM_LINES-1:0] evt_pend_q, evt_pend_d;

  logic [NUM_LINES-1:0] irq_edge;
  logic [NUM_LINES-1:0] evt_edge;
  logic [NUM_LINES-1:0] irq_set_sw;
  logic [NUM_LINES-1:0] irq_clr_sw;
  logic [NUM_LINES-1:0] evt_clr_sw;
  logic [NUM_LINES-1:0] ack_mask;
  logic [NUM_LINES-1:0] irq_active;
  logic [NUM_LINES-1:0] evt_active;

  logic unused_apb;

  assign apb_write   = PSEL && PENABLE && PWRITE;
  assign apb_read    = PSEL && PENABLE && !PWRITE;
  assign reg_idx     = reg_idx_e'(PADDR[4:2]);
  assign wdata_lines = PWDATA[NUM_LINES-1:0];
  assign unused_apb  = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  line_edge_detect #(
    .WIDTH (NUM_LINES)
  ) u_irq_edge (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .lines_i (irq_lines_i),
    .edge_o  (irq_edge)
  );

  line_edge_detect #(
    .WIDTH (NUM_LINES)
  ) u_evt_edge (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .lines_i (event_lines_i),
    .edge_o  (evt_edge)
  );

  always_comb begin
    irq_en_d   = irq_en_q;
    evt_en_d   = evt_en_q;
    irq_set_sw = '0;
    irq_clr_sw = '0;
    evt_clr_sw = '0;
    if (apb_write) begin
      unique case (reg_idx)
        RegIrqEnable: irq_en_d   = wdata_lines;
        RegIrqSet:    irq_set_sw = wdata_lines;
        RegIrqClear:  irq_clr_sw = wdata_lines;
        RegEvtEnable: evt_en_d   = wdata_lines;
        RegEvtClear:  evt_clr_sw = wdata_lines;
        default: ;
      endcase
    end
  end

  // Out-of-range ack IDs match no line and therefore clear nothing
  always_comb begin
    ack_mask = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (irq_ack_i && (irq_ack_id_i == IRQ_ID_WIDTH'(i))) ack_mask[i] = 1'b1;
    end
  end

  // Sets are OR-ed in after clears so a simultaneous set always wins
  assign irq_pend_d = (irq_pend_q & ~(irq_clr_sw | ack_mask)) | irq_edge | irq_set_sw;
  assign evt_pend_d = (evt_pend_q & ~evt_clr_sw) | evt_edge;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_en_q   <= '0;
      irq_pend_q <= '0;
      evt_en_q   <= '0;
      evt_pend_q <= '0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      evt_en_q   <= evt_en_d;
      evt_pend_q <= evt_pend_d;
    end
  end

  assign irq_active = irq_pend_q & irq_en_q;
  assign evt_active = evt_pend_q & evt_en_q;
  assign irq_o      = |irq_active;
  assign irq_id_o   = lowest_set_idx(32'(irq_active));
  assign event_o    = |evt_active;

  always_comb begin
    rdata = '0;
    unique case (reg_idx)
      RegIrqEnable:  rdata = 32'(irq_en_q);
      RegIrqPending: rdata = 32'(irq_pend_q);
      RegEvtEnable:  rdata = 32'(evt_en_q);
      RegEvtPending: rdata = 32'(evt_pend_q);
      RegStatus: begin
        rdata[STATUS_IRQ_BIT]     = irq_o;
        rdata[STATUS_EVT_BIT]     = event_o;
        rdata[IRQ_ID_WIDTH-1:0]   = irq_id_o;
      end
      default: rdata = '0;
    endcase
  end

  assign PRDATA = apb_read ? rdata : '0;

endmodule

// File: tb/tb_irq_event_ctrl.sv
// Directed self-checking bench for irq_event_ctrl in its default (unsynchronized) build.
module tb_irq_event_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] irq_lines_i;
  logic [31:0] event_lines_i;
  logic        irq_ack_i;
  logic [4:0]  irq_ack_id_i;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        event_o;

  int checks;
  int failures;
  logic [31:0] rd;

  irq_event_ctrl #(
    .APB_ADDR_WIDTH (12),
    .NUM_LINES      (32)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PWRITE        (PWRITE),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .irq_lines_i   (irq_lines_i),
    .event_lines_i (event_lines_i),
    .irq_ack_i     (irq_ack_i),
    .irq_ack_id_i  (irq_ack_id_i),
    .irq_o         (irq_o),
    .irq_id_o      (irq_id_o),
    .event_o       (event_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apb_write(input int idx, input logic [31:0] data);
    PADDR   = 12'(idx * 4);
    PWDATA  = data;
    PWRITE  = 1'b1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    step();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic apb_read(input int idx, output logic [31:0] data);
    PADDR   = 12'(idx * 4);
    PWRITE  = 1'b0;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    step();
    PENABLE = 1'b1;
    #1;
    data = PRDATA;
    step();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic pulse_irq(input logic [31:0] mask);
    irq_lines_i = mask;
    step();
    irq_lines_i = '0;
  endtask

  task automatic ack(input logic [4:0] id);
    irq_ack_i    = 1'b1;
    irq_ack_id_i = id;
    step();
    irq_ack_i    = 1'b0;
    irq_ack_id_i = '0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    HRESETn       = 1'b0;
    PADDR         = '0;
    PWDATA        = '0;
    PWRITE        = 1'b0;
    PSEL          = 1'b0;
    PENABLE       = 1'b0;
    irq_lines_i   = '0;
    event_lines_i = '0;
    irq_ack_i     = 1'b0;
    irq_ack_id_i  = '0;

    // Reset state
    #12;
    check("reset_irq_o", 32'(irq_o), 32'd0);
    check("reset_irq_id", 32'(irq_id_o), 32'd0);
    check("reset_event_o", 32'(event_o), 32'd0);
    check("reset_prdata", PRDATA, 32'd0);
    check("pready_tied", 32'(PREADY), 32'd1);
    check("pslverr_tied", 32'(PSLVERR), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();

    // Priority encoding and ack sequencing
    apb_write(0, 32'h28);
    pulse_irq(32'h28);
    check("t1_irq_o", 32'(irq_o), 32'd1);
    check("t1_irq_id_3", 32'(irq_id_o), 32'd3);
    ack(5'd3);
    check("t1_ack3_irq_o", 32'(irq_o), 32'd1);
    check("t1_ack3_id_5", 32'(irq_id_o), 32'd5);
    ack(5'd5);
    check("t1_ack5_irq_o", 32'(irq_o), 32'd0);
    check("t1_ack5_id", 32'(irq_id_o), 32'd0);

    // Pending latches while masked; enabling later raises irq_o
    apb_write(0, 32'h0);
    pulse_irq(32'h80);
    apb_read(1, rd);
    check("t2_pending_masked", rd, 32'h80);
    check("t2_irq_o_masked", 32'(irq_o), 32'd0);
    apb_write(0, 32'h80);
    check("t2_irq_o_enabled", 32'(irq_o), 32'd1);
    check("t2_irq_id_7", 32'(irq_id_o), 32'd7);
    apb_write(3, 32'h80);
    check("t2_cleared", 32'(irq_o), 32'd0);

    // Edge on line 2 concurrent with IRQ_CLEAR of bit 2: set wins
    PADDR   = 12'(3 * 4);
    PWDATA  = 32'h4;
    PWRITE  = 1'b1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    step();
    PENABLE     = 1'b1;
    irq_lines_i = 32'h4;
    step();
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    PWRITE      = 1'b0;
    irq_lines_i = '0;
    apb_read(1, rd);
    check("t3_set_beats_clear", rd, 32'h4);
    apb_write(3, 32'h4);
    apb_read(1, rd);
    check("t3_clear_after", rd, 32'h0);

    // Event level held until software clear
    apb_write(4, 32'h1);
    event_lines_i = 32'h1;
    step();
    event_lines_i = '0;
    check("t4_event_o", 32'(event_o), 32'd1);
    repeat (10) step();
    check("t4_event_held", 32'(event_o), 32'd1);
    apb_read(5, rd);
    check("t4_evt_pending", rd, 32'h1);
    apb_read(7, rd);
    check("t4_status_evt", rd, 32'h4000_0000);
    apb_write(6, 32'h1);
    check("t4_event_cleared", 32'(event_o), 32'd0);
    apb_read(7, rd);
    check("t4_status_clear", rd, 32'h0);

    // Software set and an out-of-range/non-pending ack
    apb_write(0, 32'h1);
    apb_write(2, 32'h1);
    check("t5_irq_o_set", 32'(irq_o), 32'd1);
    apb_read(7, rd);
    check("t5_status", rd, 32'h8000_0000);
    ack(5'd31);
    check("t5_ack31_irq_o", 32'(irq_o), 32'd1);
    apb_read(1, rd);
    check("t5_ack31_pending", rd, 32'h1);
    apb_read(2, rd);
    check("t5_set_reads_0", rd, 32'h0);
    apb_read(0, rd);
    check("t5_enable_rb", rd, 32'h1);

    // Line held high through reset release registers one edge
    HRESETn     = 1'b0;
    irq_lines_i = 32'h10;
    #1;
    check("t6_async_reset_irq_o", 32'(irq_o), 32'd0);
    repeat (2) step();
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    apb_read(1, rd);
    check("t6_pending_bit4", rd, 32'h10);
    check("t6_irq_o_masked", 32'(irq_o), 32'd0);
    apb_write(0, 32'h10);
    check("t6_irq_o", 32'(irq_o), 32'd1);
    check("t6_irq_id_4", 32'(irq_id_o), 32'd4);
    apb_write(4, 32'h1);
    event_lines_i = 32'h1;
    step();
    event_lines_i = '0;
    check("t6_event_o", 32'(event_o), 32'd1);

    // Mid-interrupt asynchronous reset
    #2;
    HRESETn = 1'b0;
    #1;
    check("t6_rst_irq_o", 32'(irq_o), 32'd0);
    check("t6_rst_irq_id", 32'(irq_id_o), 32'd0);
    check("t6_rst_event_o", 32'(event_o), 32'd0);
    irq_lines_i = '0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    apb_read(0, rd);
    check("t6_rst_enable", rd, 32'h0);
    check("t6_post_irq_o", 32'(irq_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
